// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the receiver echo path
// (requester 0) and an external byte source (requester 1).
module uart_tx_arbiter #(
    parameter int BUSY_WAIT = 16
) (
    input  logic       clock_50MHz,
    input  logic       reset,
    input  logic       rx_rdy,
    input  logic [7:0] rx_dout,
    output logic       rx_rdy_clr,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ack,
    output logic [7:0] tx_din,
    output logic       tx_enable,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       timeout_err,
    output logic [1:0] o_dbg_state
);

    localparam int CW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_grant, w_grant_nxt;
    logic [7:0]      r_tx_din, w_tx_din_nxt;
    logic            r_tx_enable, w_tx_enable_nxt;
    logic            r_req1_ack, w_req1_ack_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_timeout_err, w_timeout_err_nxt;
    logic            r_last_req1, w_last_req1_nxt;
    logic            r_echo_full;
    logic [7:0]      r_echo_data;
    logic            r_rx_rdy_clr;
    logic            w_release;
    logic            w_echo_wins;

    // Handshakes: rx_rdy stays high with rx_dout stable until a one-cycle rx_rdy_clr;
    // req1_valid stays high with req1_data stable until a one-cycle req1_ack.
    assign w_echo_wins = r_echo_full && (!req1_valid || r_last_req1);

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_tx_din_nxt      = r_tx_din;
        w_tx_enable_nxt   = 1'b0;
        w_req1_ack_nxt    = 1'b0;
        w_cnt_nxt         = r_cnt;
        w_timeout_err_nxt = r_timeout_err;
        w_last_req1_nxt   = r_last_req1;
        w_release         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!tx_busy && (r_echo_full || req1_valid)) begin
                    w_state_nxt     = LOAD;
                    w_tx_enable_nxt = 1'b1;
                    if (w_echo_wins) begin
                        w_grant_nxt  = 2'b01;
                        w_tx_din_nxt = r_echo_data;
                    end else begin
                        w_grant_nxt    = 2'b10;
                        w_tx_din_nxt   = req1_data;
                        w_req1_ack_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                w_state_nxt = WAIT_BUSY;
                w_cnt_nxt   = '0;
                w_release   = r_grant[0];
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt == CW'(BUSY_WAIT - 1)) begin
                    // Transmitter never started: drop the byte, do not retry.
                    w_state_nxt       = IDLE;
                    w_grant_nxt       = 2'b00;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt     = IDLE;
                    w_grant_nxt     = 2'b00;
                    w_last_req1_nxt = r_grant[1];
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_50MHz) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= 2'b00;
            r_tx_din      <= 8'h00;
            r_tx_enable   <= 1'b0;
            r_req1_ack    <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_last_req1   <= 1'b1;
            r_echo_full   <= 1'b0;
            r_echo_data   <= 8'h00;
            r_rx_rdy_clr  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_tx_din      <= w_tx_din_nxt;
            r_tx_enable   <= w_tx_enable_nxt;
            r_req1_ack    <= w_req1_ack_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_last_req1   <= w_last_req1_nxt;
            r_rx_rdy_clr  <= 1'b0;
            // Release happens only while full, so a capture waits one more cycle.
            if (w_release) begin
                r_echo_full <= 1'b0;
            end else if (rx_rdy && !r_echo_full) begin
                r_echo_full  <= 1'b1;
                r_echo_data  <= rx_dout;
                r_rx_rdy_clr <= 1'b1;
            end
        end
    end

    assign rx_rdy_clr  = r_rx_rdy_clr;
    assign req1_ack    = r_req1_ack;
    assign tx_din      = r_tx_din;
    assign tx_enable   = r_tx_enable;
    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, then randomized traffic checked
// against a transfer-level reference model.
module tb_uart_tx_arbiter;

    localparam int BW = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_dout;
    logic       rx_rdy_clr;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ack;
    logic [7:0] tx_din;
    logic       tx_enable;
    logic       tx_busy;
    logic [1:0] grant;
    logic       timeout_err;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    // clock / reset
    always #10 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    uart_tx_arbiter #(.BUSY_WAIT(BW)) dut (
        .clock_50MHz(clk),
        .reset(rst),
        .rx_rdy(rx_rdy),
        .rx_dout(rx_dout),
        .rx_rdy_clr(rx_rdy_clr),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ack(req1_ack),
        .tx_din(tx_din),
        .tx_enable(tx_enable),
        .tx_busy(tx_busy),
        .grant(grant),
        .timeout_err(timeout_err),
        .o_dbg_state(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_rdy_clr) rx_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_rdy = 1'b0; rx_dout = 8'h00;
        req1_valid = 1'b0; req1_data = 8'h00; tx_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [1:0] g, input logic [7:0] b, input int max_wait);
        int n = 1;
        tick();
        while (!tx_enable && n < max_wait) begin
            tick();
            n++;
        end
        check_eq({tag, " enable"}, 32'(tx_enable), 32'd1);
        check_eq({tag, " grant"}, 32'(grant), 32'(g));
        check_eq({tag, " din"}, 32'(tx_din), 32'(b));
        check_eq({tag, " ack"}, 32'(req1_ack), 32'(g[1]));
        if (req1_ack) req1_valid = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [1:0] g, input int len);
        tx_busy = 1'b1;
        tick();
        check_eq({tag, " enable pulse"}, 32'(tx_enable), 32'd0);
        for (int i = 1; i < len; i++) tick();
        check_eq({tag, " grant held"}, 32'(grant), 32'(g));
        tx_busy = 1'b0;
        tick();
        check_eq({tag, " release"}, 32'(grant), 32'd0);
    endtask

    // reference model state
    logic       m_echo_full, m_last_req1, m_err, m_active, m_seen, m_win_req1, m_release;
    logic [7:0] m_echo_byte;
    int         m_cyc;
    logic       d_rx_rdy, d_req_v, d_busy;
    logic [7:0] d_rx_dout, d_req_d;
    logic       t_on;
    int         t_del, t_len;

    task automatic random_run(input int ncyc);
        logic exp_en, exp_clr, rel_now;
        logic [7:0] eb;
        m_echo_full = 1'b0; m_last_req1 = 1'b1; m_err = 1'b0; m_active = 1'b0;
        m_seen = 1'b0; m_win_req1 = 1'b0; m_release = 1'b0; m_cyc = 0;
        m_echo_byte = 8'h00; t_on = 1'b0; t_del = 0; t_len = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            d_rx_rdy = rx_rdy; d_rx_dout = rx_dout;
            d_req_v = req1_valid; d_req_d = req1_data; d_busy = tx_busy;
            tick();
            rel_now = m_release;
            m_release = 1'b0;
            if (m_active) begin
                m_cyc++;
                if (!m_seen && d_busy && m_cyc >= 2) begin
                    m_seen = 1'b1;
                end else if (m_seen && !d_busy) begin
                    m_active = 1'b0;
                    m_last_req1 = m_win_req1;
                    void'(exp_q.pop_front());
                end else if (!m_seen && m_cyc == BW + 1) begin
                    m_active = 1'b0;
                    m_err = 1'b1;
                    void'(exp_q.pop_front());
                end
                check_eq("rnd enable off", 32'(tx_enable), 32'd0);
                if (m_active) begin
                    check_eq("rnd grant hold", 32'(grant), m_win_req1 ? 32'd2 : 32'd1);
                    check_eq("rnd din stable", 32'(tx_din), 32'(exp_q[0]));
                end else begin
                    check_eq("rnd release", 32'(grant), 32'd0);
                end
            end else begin
                exp_en = !d_busy && (m_echo_full || d_req_v);
                check_eq("rnd enable", 32'(tx_enable), 32'(exp_en));
                if (exp_en) begin
                    m_win_req1 = !(m_echo_full && (!d_req_v || m_last_req1));
                    eb = m_win_req1 ? d_req_d : m_echo_byte;
                    check_eq("rnd grant", 32'(grant), m_win_req1 ? 32'd2 : 32'd1);
                    check_eq("rnd din", 32'(tx_din), 32'(eb));
                    check_eq("rnd ack", 32'(req1_ack), 32'(m_win_req1));
                    exp_q.push_back(eb);
                    m_active = 1'b1; m_cyc = 0; m_seen = 1'b0;
                    m_release = !m_win_req1;
                end else begin
                    check_eq("rnd idle grant", 32'(grant), 32'd0);
                end
            end
            exp_clr = d_rx_rdy && !m_echo_full;
            check_eq("rnd rx_rdy_clr", 32'(rx_rdy_clr), 32'(exp_clr));
            if (rel_now) m_echo_full = 1'b0;
            if (exp_clr) begin
                m_echo_full = 1'b1;
                m_echo_byte = d_rx_dout;
            end
            check_eq("rnd timeout_err", 32'(timeout_err), 32'(m_err));
            // transmitter responder: busy after a short delay, or never (timeout)
            if (tx_enable) begin
                if ($urandom_range(7) == 0) begin
                    t_on = 1'b0;
                end else begin
                    t_on = 1'b1;
                    t_del = $urandom_range(3);
                    t_len = $urandom_range(6, 2);
                end
            end
            if (t_on) begin
                if (t_del > 0) begin
                    t_del--; tx_busy = 1'b0;
                end else if (t_len > 0) begin
                    tx_busy = 1'b1; t_len--;
                end else begin
                    tx_busy = 1'b0; t_on = 1'b0;
                end
            end else begin
                tx_busy = 1'b0;
            end
            if (!rx_rdy && $urandom_range(3) == 0) begin
                rx_rdy = 1'b1;
                rx_dout = 8'($urandom);
            end
            if (req1_valid && req1_ack) begin
                req1_valid = 1'b0;
            end else if (req1_valid && $urandom_range(19) == 0) begin
                req1_valid = 1'b0;
            end else if (!req1_valid && $urandom_range(3) == 0) begin
                req1_valid = 1'b1;
                req1_data = 8'($urandom);
            end
        end
    endtask

    initial begin
        // reset values and single echo transfer
        do_reset();
        check_eq("rst grant", 32'(grant), 32'd0);
        check_eq("rst tx_enable", 32'(tx_enable), 32'd0);
        check_eq("rst req1_ack", 32'(req1_ack), 32'd0);
        check_eq("rst rx_rdy_clr", 32'(rx_rdy_clr), 32'd0);
        check_eq("rst tx_din", 32'(tx_din), 32'd0);
        check_eq("rst timeout_err", 32'(timeout_err), 32'd0);
        rx_rdy = 1'b1; rx_dout = 8'hA5;
        tick();
        check_eq("echo clr pulse", 32'(rx_rdy_clr), 32'd1);
        check_eq("echo no early enable", 32'(tx_enable), 32'd0);
        expect_tx("echo", 2'b01, 8'hA5, 1);
        check_eq("echo clr single", 32'(rx_rdy_clr), 32'd0);
        serve("echo", 2'b01, 10);

        // tie and alternation
        do_reset();
        tx_busy = 1'b1; rx_rdy = 1'b1; rx_dout = 8'h11; req1_valid = 1'b1; req1_data = 8'h3C;
        tick(); tick();
        check_eq("tie busy blocks", 32'(tx_enable), 32'd0);
        tx_busy = 1'b0;
        expect_tx("tie1", 2'b01, 8'h11, 1);
        rx_rdy = 1'b1; rx_dout = 8'h22;
        serve("tie1", 2'b01, 3);
        expect_tx("tie2", 2'b10, 8'h3C, 1);
        req1_valid = 1'b1; req1_data = 8'h4D;
        serve("tie2", 2'b10, 3);
        expect_tx("tie3", 2'b01, 8'h22, 1);
        serve("tie3", 2'b01, 3);
        expect_tx("tie4", 2'b10, 8'h4D, 1);
        serve("tie4", 2'b10, 3);

        // backpressure on the echo register
        do_reset();
        req1_valid = 1'b1; req1_data = 8'h5A;
        expect_tx("bp req1", 2'b10, 8'h5A, 1);
        tx_busy = 1'b1; rx_rdy = 1'b1; rx_dout = 8'h61;
        tick();
        check_eq("bp first capture", 32'(rx_rdy_clr), 32'd1);
        rx_rdy = 1'b1; rx_dout = 8'h62;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("bp hold", 32'(rx_rdy_clr), 32'd0);
        end
        tx_busy = 1'b0;
        tick();
        check_eq("bp req1 release", 32'(grant), 32'd0);
        expect_tx("bp echo", 2'b01, 8'h61, 1);
        check_eq("bp clr at load", 32'(rx_rdy_clr), 32'd0);
        tick();
        check_eq("bp blocked after load", 32'(rx_rdy_clr), 32'd0);
        tick();
        check_eq("bp second capture", 32'(rx_rdy_clr), 32'd1);
        serve("bp echo", 2'b01, 3);
        expect_tx("bp echo2", 2'b01, 8'h62, 1);
        serve("bp echo2", 2'b01, 2);

        // busy never rises: timeout then recovery
        do_reset();
        req1_valid = 1'b1; req1_data = 8'hC3;
        expect_tx("to", 2'b10, 8'hC3, 1);
        for (int i = 0; i < BW; i++) tick();
        check_eq("to not yet", 32'(timeout_err), 32'd0);
        check_eq("to grant before", 32'(grant), 32'd2);
        tick();
        check_eq("to flag", 32'(timeout_err), 32'd1);
        check_eq("to grant cleared", 32'(grant), 32'd0);
        req1_valid = 1'b1; req1_data = 8'h77;
        expect_tx("to next", 2'b10, 8'h77, 1);
        serve("to next", 2'b10, 4);
        check_eq("to sticky", 32'(timeout_err), 32'd1);

        // reset during WAIT_DONE with the transmitter still busy
        req1_valid = 1'b1; req1_data = 8'h44;
        expect_tx("rst mid", 2'b10, 8'h44, 1);
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; req1_valid = 1'b1; req1_data = 8'h99;
        tick();
        rst = 1'b0;
        check_eq("rstmid grant", 32'(grant), 32'd0);
        check_eq("rstmid tx_enable", 32'(tx_enable), 32'd0);
        check_eq("rstmid ack", 32'(req1_ack), 32'd0);
        check_eq("rstmid clr", 32'(rx_rdy_clr), 32'd0);
        check_eq("rstmid tx_din", 32'(tx_din), 32'd0);
        check_eq("rstmid timeout_err", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rstmid wait busy", 32'(tx_enable), 32'd0);
        end
        tx_busy = 1'b0;
        expect_tx("rstmid resume", 2'b10, 8'h99, 1);
        serve("rstmid resume", 2'b10, 3);

        // randomized traffic
        do_reset();
        random_run(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
